// File: rtl/branch_target_buffer_pkg.sv
// Shared definitions for the branch target buffer.
// - FSM state encoding (idle / invalidate sweep).
// - Saturating-counter constants as functions of counter width.
// - PC index/tag field extraction helpers (operate on a 128-bit zero-extended PC).
package branch_target_buffer_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StSweep = 1'b1
  } btb_state_e;

  function automatic int unsigned cnt_max(input int unsigned w);
    return (1 << w) - 1;
  endfunction

  function automatic int unsigned cnt_weak_t(input int unsigned w);
    return 1 << (w - 1);
  endfunction

  function automatic int unsigned cnt_weak_nt(input int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic logic [127:0] low_mask(input int unsigned width);
    return ~({128{1'b1}} << width);
  endfunction

  // index = pc[idx_w+1:2]
  function automatic logic [127:0] pc_index(input logic [127:0] pc, input int unsigned idx_w);
    return (pc >> 2) & low_mask(idx_w);
  endfunction

  // tag = pc[idx_w+1+tag_w:idx_w+2]
  function automatic logic [127:0] pc_tag(input logic [127:0] pc, input int unsigned idx_w,
                                          input int unsigned tag_w);
    return (pc >> (idx_w + 2)) & low_mask(tag_w);
  endfunction

endpackage

// File: rtl/branch_target_buffer_sat_counter.sv
// Saturating up/down next-value logic.
// Ports:
//   value      - current count
//   up / down  - step request; both or neither leaves the value unchanged
//   next_value - value stepped by one, clamped at 0 and all-ones
module sat_counter #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] value,
  input  logic         up,
  input  logic         down,
  output logic [W-1:0] next_value
);

  always_comb begin
    next_value = value;
    if (up && !down) begin
      if (value != {W{1'b1}}) next_value = value + W'(1);
    end else if (down && !up) begin
      if (value != '0) next_value = value - W'(1);
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with per-entry tag, target and saturating counter.
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   enable              - global run enable; freezes all state when low
//   lookup_pc           - IF-stage PC; pred_hit/pred_taken/pred_target are combinational
//   upd_*               - resolved branch update from ID, applied at the clock edge
//   clear_req           - starts a DEPTH-cycle invalidate sweep; busy is high while it runs
//   mispredict_cnt      - saturating count of resolved mispredictions
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int unsigned PC_W   = 64,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned TAG_W  = 10,
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned STAT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [PC_W-1:0]   lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic [PC_W-1:0]   upd_target,
  input  logic              upd_taken,
  input  logic              upd_pred_taken,
  input  logic              clear_req,
  output logic              busy,
  output logic [STAT_W-1:0] mispredict_cnt
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CntWeakT  = CNT_W'(cnt_weak_t(CNT_W));
  localparam logic [CNT_W-1:0] CntWeakNt = CNT_W'(cnt_weak_nt(CNT_W));
  localparam logic [IDX_W-1:0] PtrLast   = IDX_W'(DEPTH - 1);

  logic              valid_q  [DEPTH];
  logic [TAG_W-1:0]  tag_q    [DEPTH];
  logic [PC_W-1:0]   target_q [DEPTH];
  logic [CNT_W-1:0]  cnt_q    [DEPTH];

  btb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [STAT_W-1:0] stat_q, stat_d;

  logic [IDX_W-1:0]  lk_idx, upd_idx;
  logic [TAG_W-1:0]  lk_tag, upd_tag;
  logic              lk_match, upd_hit, upd_apply, sweep_clr, mispredict;
  logic [CNT_W-1:0]  cnt_next;

  assign lk_idx  = IDX_W'(pc_index(128'(lookup_pc), IDX_W));
  assign lk_tag  = TAG_W'(pc_tag(128'(lookup_pc), IDX_W, TAG_W));
  assign upd_idx = IDX_W'(pc_index(128'(upd_pc), IDX_W));
  assign upd_tag = TAG_W'(pc_tag(128'(upd_pc), IDX_W, TAG_W));

  // Lookup reads pre-edge state; predictions are suppressed while sweeping.
  assign lk_match    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_hit    = (state_q == StIdle) && lk_match;
  assign pred_taken  = pred_hit && cnt_q[lk_idx][CNT_W-1];
  assign pred_target = pred_hit ? target_q[lk_idx] : '0;
  assign busy        = (state_q == StSweep);

  assign upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_apply  = upd_valid && (state_q == StIdle);
  assign sweep_clr  = (state_q == StSweep);
  assign mispredict = upd_valid && (upd_taken != upd_pred_taken);

  sat_counter #(
    .W (CNT_W)
  ) u_upd_cnt (
    .value      (cnt_q[upd_idx]),
    .up         (upd_taken),
    .down       (!upd_taken),
    .next_value (cnt_next)
  );

  sat_counter #(
    .W (STAT_W)
  ) u_stat_cnt (
    .value      (stat_q),
    .up         (mispredict),
    .down       (1'b0),
    .next_value (stat_d)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      StIdle: begin
        if (clear_req) begin
          state_d = StSweep;
          ptr_d   = '0;
        end
      end
      StSweep: begin
        ptr_d = ptr_q + IDX_W'(1);
        if (ptr_q == PtrLast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      stat_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= CntWeakNt;
      end
    end else if (enable) begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      stat_q  <= stat_d;
      if (sweep_clr) begin
        valid_q[ptr_q] <= 1'b0;
        cnt_q[ptr_q]   <= CntWeakNt;
      end
      if (upd_apply) begin
        if (upd_hit) begin
          cnt_q[upd_idx] <= cnt_next;
          if (upd_taken) target_q[upd_idx] <= upd_target;
        end else if (upd_taken) begin
          // Taken-only allocation; replaces whatever occupied the index.
          valid_q[upd_idx]  <= 1'b1;
          tag_q[upd_idx]    <= upd_tag;
          target_q[upd_idx] <= upd_target;
          cnt_q[upd_idx]    <= CntWeakT;
        end
      end
    end
  end

  assign mispredict_cnt = stat_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [63:0] lookup_pc, upd_pc, upd_target, pred_target;
  logic        pred_hit, pred_taken, upd_valid, upd_taken, upd_pred_taken, clear_req, busy;
  logic [3:0]  mispredict_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_target_buffer #(
    .PC_W   (64),
    .DEPTH  (64),
    .TAG_W  (10),
    .CNT_W  (2),
    .STAT_W (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .lookup_pc      (lookup_pc),
    .pred_hit       (pred_hit),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_target     (upd_target),
    .upd_taken      (upd_taken),
    .upd_pred_taken (upd_pred_taken),
    .clear_req      (clear_req),
    .busy           (busy),
    .mispredict_cnt (mispredict_cnt)
  );

  typedef struct {
    logic        en;
    logic        uv;
    logic [63:0] upc;
    logic [63:0] utgt;
    logic        ut;
    logic        upt;
    logic [63:0] lpc;
    logic        hit;
    logic        tk;
    logic [63:0] tgt;
    logic [3:0]  mis;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enable         = 1'b1;
    upd_valid      = 1'b0;
    upd_pc         = '0;
    upd_target     = '0;
    upd_taken      = 1'b0;
    upd_pred_taken = 1'b0;
    clear_req      = 1'b0;
  endtask

  task automatic do_update(input logic [63:0] pc, input logic [63:0] tgt, input logic tk,
                           input logic ptk);
    upd_valid = 1'b1; upd_pc = pc; upd_target = tgt; upd_taken = tk; upd_pred_taken = ptk;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic expect_miss(input string name, input logic [63:0] pc);
    lookup_pc = pc;
    #1;
    check(name, {63'd0, pred_hit}, 64'd0);
  endtask

  // Runs a sweep starting from the current (busy) state and returns the busy-cycle count.
  // Enable is dropped for freeze_len cycles starting at busy cycle freeze_at.
  task automatic run_sweep(input int freeze_at, input int freeze_len, output int n);
    int guard;
    n = 0;
    guard = 0;
    while (busy && guard < 300) begin
      n++;
      guard++;
      enable    = !(n >= freeze_at && n < freeze_at + freeze_len);
      upd_valid = 1'b0;
      clear_req = (n == 10);
      if (n == 5) begin
        // Ignored by the table, but the mispredict counter still counts it.
        upd_valid = 1'b1; upd_pc = 64'h300; upd_target = 64'h777;
        upd_taken = 1'b1; upd_pred_taken = 1'b0;
      end
      lookup_pc = 64'h200;
      #1;
      if (n == 20) begin
        check("sweep_hit_forced", {63'd0, pred_hit}, 64'd0);
        check("sweep_target_forced", pred_target, 64'd0);
      end
      tick();
    end
    if (guard >= 300) $display("FAIL sweep_timeout: got %0d cycles expected sweep to end", guard);
    idle_inputs();
  endtask

  initial begin
    int n;
    //            en    uv    upc      utgt     ut    upt   lpc      hit   tk    tgt      mis
    vecs[0]  = '{1'b1, 1'b1, 64'h100, 64'h200, 1'b1, 1'b0, 64'h100, 1'b1, 1'b1, 64'h200, 4'd1};
    vecs[1]  = '{1'b1, 1'b1, 64'h100, 64'h200, 1'b1, 1'b1, 64'h100, 1'b1, 1'b1, 64'h200, 4'd1};
    vecs[2]  = '{1'b1, 1'b1, 64'h100, 64'h200, 1'b1, 1'b1, 64'h100, 1'b1, 1'b1, 64'h200, 4'd1};
    vecs[3]  = '{1'b1, 1'b1, 64'h100, 64'h200, 1'b1, 1'b1, 64'h100, 1'b1, 1'b1, 64'h200, 4'd1};
    vecs[4]  = '{1'b1, 1'b1, 64'h100, 64'h200, 1'b1, 1'b1, 64'h100, 1'b1, 1'b1, 64'h200, 4'd1};
    // ctr 3 -> 2 -> 1; target untouched by not-taken updates
    vecs[5]  = '{1'b1, 1'b1, 64'h100, 64'h999, 1'b0, 1'b1, 64'h100, 1'b1, 1'b1, 64'h200, 4'd2};
    vecs[6]  = '{1'b1, 1'b1, 64'h100, 64'h999, 1'b0, 1'b1, 64'h100, 1'b1, 1'b0, 64'h200, 4'd3};
    // same index, different tag: replacement
    vecs[7]  = '{1'b1, 1'b1, 64'h200, 64'h400, 1'b1, 1'b0, 64'h100, 1'b0, 1'b0, 64'h0,   4'd4};
    vecs[8]  = '{1'b1, 1'b0, 64'h0,   64'h0,   1'b0, 1'b0, 64'h200, 1'b1, 1'b1, 64'h400, 4'd4};
    // not-taken miss does not allocate
    vecs[9]  = '{1'b1, 1'b1, 64'h104, 64'h555, 1'b0, 1'b1, 64'h104, 1'b0, 1'b0, 64'h0,   4'd5};
    vecs[10] = '{1'b1, 1'b1, 64'h108, 64'h888, 1'b1, 1'b1, 64'h108, 1'b1, 1'b1, 64'h888, 4'd5};
    // taken hit overwrites target
    vecs[11] = '{1'b1, 1'b1, 64'h200, 64'h404, 1'b1, 1'b0, 64'h200, 1'b1, 1'b1, 64'h404, 4'd6};
    // enable low: nothing changes, not even the mispredict count
    vecs[12] = '{1'b0, 1'b1, 64'h200, 64'h0,   1'b0, 1'b1, 64'h200, 1'b1, 1'b1, 64'h404, 4'd6};

    idle_inputs();
    reset = 1'b1;
    lookup_pc = 64'h100;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_hit", {63'd0, pred_hit}, 64'd0);
    check("rst_taken", {63'd0, pred_taken}, 64'd0);
    check("rst_target", pred_target, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_mis", {60'd0, mispredict_cnt}, 64'd0);

    for (int i = 0; i < 13; i++) begin
      enable = vecs[i].en; upd_valid = vecs[i].uv; upd_pc = vecs[i].upc;
      upd_target = vecs[i].utgt; upd_taken = vecs[i].ut; upd_pred_taken = vecs[i].upt;
      tick();
      idle_inputs();
      lookup_pc = vecs[i].lpc;
      #1;
      check($sformatf("v%0d_hit", i), {63'd0, pred_hit}, {63'd0, vecs[i].hit});
      check($sformatf("v%0d_taken", i), {63'd0, pred_taken}, {63'd0, vecs[i].tk});
      check($sformatf("v%0d_target", i), pred_target, vecs[i].tgt);
      check($sformatf("v%0d_mis", i), {60'd0, mispredict_cnt}, {60'd0, vecs[i].mis});
    end

    // Sweep started together with an update; both take effect.
    clear_req = 1'b1;
    upd_valid = 1'b1; upd_pc = 64'h10C; upd_target = 64'h999;
    upd_taken = 1'b1; upd_pred_taken = 1'b1;
    tick();
    idle_inputs();
    check("sweep_busy_start", {63'd0, busy}, 64'd1);
    run_sweep(1000, 0, n);
    check("sweep_len", 64'(n), 64'd64);
    check("sweep_mis", {60'd0, mispredict_cnt}, 64'd7);
    expect_miss("post_sweep_200", 64'h200);
    expect_miss("post_sweep_108", 64'h108);
    expect_miss("post_sweep_10c", 64'h10C);
    expect_miss("post_sweep_300", 64'h300);

    // Sweep with enable low for 5 cycles.
    do_update(64'h200, 64'h400, 1'b1, 1'b1);
    lookup_pc = 64'h200;
    #1;
    check("refill_hit", {63'd0, pred_hit}, 64'd1);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    run_sweep(30, 5, n);
    check("sweep_freeze_len", 64'(n), 64'd69);
    expect_miss("post_freeze_200", 64'h200);

    // Reset in the middle of a sweep; entry at index 50 is beyond the sweep pointer.
    do_update(64'h200, 64'h400, 1'b1, 1'b1);
    do_update(64'hC8, 64'h123, 1'b1, 1'b0);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("mid_sweep_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_mis", {60'd0, mispredict_cnt}, 64'd0);
    expect_miss("abort_miss_200", 64'h200);
    expect_miss("abort_miss_c8", 64'hC8);

    // Mispredict counter saturation at 4'hF.
    for (int i = 0; i < 20; i++) begin
      do_update(64'h104, 64'h0, 1'b0, 1'b1);
      if (i == 13) check("mis_14", {60'd0, mispredict_cnt}, 64'd14);
    end
    check("mis_sat", {60'd0, mispredict_cnt}, 64'd15);
    expect_miss("mis_no_alloc", 64'h104);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Parametrised branch target buffer: a direct-mapped table of tag, target and N-bit saturating counter per entry.
- Successor to the single-entry IF-stage branch prediction table.
- Lookup is combinational from the IF-stage PC and drives the PC select mux. Resolution updates arrive from the ID stage on the following clock edge.
- Adds: configurable depth, tag width and counter width; taken-only allocation; a sequential invalidate sweep; a saturating mispredict statistics counter.

Parameters:
- PC_W, 64, program counter and target width.
- DEPTH, 64, number of entries; power of 2, 2..1024.
- IDX_W, $clog2(DEPTH), index width (derived; never overridden).
- TAG_W, 10, stored tag width; IDX_W+2+TAG_W <= PC_W.
- CNT_W, 2, saturating counter width, 1..4.
- STAT_W, 32, mispredict counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  global run enable; when 0, no state changes except reset.
- lookup_pc  in  PC_W  IF-stage PC.
- pred_hit  out  1  valid entry with matching tag.
- pred_taken  out  1  pred_hit & counter MSB.
- pred_target  out  PC_W  stored target when pred_hit, else 0.
- upd_valid  in  1  resolved branch update this cycle.
- upd_pc  in  PC_W  PC of the resolved branch.
- upd_target  in  PC_W  resolved target.
- upd_taken  in  1  actual outcome.
- upd_pred_taken  in  1  prediction that was used for this branch.
- clear_req  in  1  start invalidate sweep (pulse).
- busy  out  1  sweep in progress.
- mispredict_cnt  out  STAT_W  saturating count of mispredictions.

Behaviour:
- Address fields:
  - index = pc[IDX_W+1:2].
  - tag = pc[IDX_W+1+TAG_W:IDX_W+2].
- Lookup:
  - Purely combinational, zero latency.
  - Sees pre-edge state: no bypass from an update at the same index in the same cycle.
- Reset (reset=1 at an edge, regardless of enable):
  - All valid bits cleared, counters set to 2^(CNT_W-1)-1 (weakly not-taken).
  - Targets and tags don't-care.
  - FSM goes to IDLE; mispredict_cnt = 0.
  - Outputs after reset: pred_hit=0, pred_taken=0, pred_target=0, busy=0.
- Update, applied at the edge when enable & upd_valid & state==IDLE:
  - Hit (entry valid, tag equal):
    - Counter += 1 if upd_taken, saturating at 2^CNT_W-1.
    - Counter -= 1 if not taken, saturating at 0.
    - Target overwritten only when upd_taken.
  - Miss and upd_taken: allocate/replace. valid=1, tag, target written; counter = 2^(CNT_W-1) (weakly taken).
  - Miss and not taken: no change.
- Mispredict counter:
  - Increments when enable & upd_valid & (upd_taken != upd_pred_taken).
  - Counts in every state, including SWEEP.
  - Saturates at all-ones.
- FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP on enable & clear_req. The sweep pointer is loaded with 0.
  - In SWEEP, each enabled cycle: valid[ptr]=0, counter[ptr]=weakly not-taken, ptr += 1.
  - SWEEP -> IDLE on the edge that clears ptr==DEPTH-1. Total = DEPTH enabled cycles.
  - busy=1 throughout SWEEP.
  - pred_hit and pred_taken forced to 0 in SWEEP; pred_target=0.
  - Table updates ignored in SWEEP.
  - clear_req during SWEEP is ignored (no restart).
  - enable=0 freezes ptr and state.
- Simultaneous events:
  - clear_req and upd_valid in IDLE at the same edge: the update is applied, then the sweep starts next cycle.
  - reset wins over everything.
  - Reset mid-sweep aborts to IDLE with all entries invalid.
- Aliasing: different PCs with equal index and equal tag share an entry. This is accepted; there is no full-PC compare.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=0, SWEEP=1).
  - Counter helper constants: CNT_MAX, CNT_WEAK_T, CNT_WEAK_NT as functions of CNT_W.
  - Index/tag slice helper functions.
- One sub-module: sat_counter (CNT_W-wide up/down saturating next-value logic). It is instanced once on the update path and reused for mispredict_cnt with width STAT_W, up-only.

Test Plan:
- Reset, then lookup_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0, busy=0, mispredict_cnt=0.
- Update pc=0x100, target=0x200, taken=1, pred_taken=0 -> next cycle lookup 0x100 gives hit=1, taken=1 (ctr=2), target=0x200, mispredict_cnt=1.
- Counter saturation (default CNT_W=2):
  - Four more taken updates at 0x100 -> ctr stays 3.
  - Then two not-taken updates -> ctr=1, pred_taken=0, hit=1, target still 0x200.
- Aliasing/replacement with DEPTH=64:
  - Taken update pc=0x100+0x100 (same index, different tag), target=0x400 -> lookup 0x100 misses; lookup 0x200 hits with target 0x400.
  - Not-taken miss at a fresh index -> no allocation.
- clear_req pulse with entries valid:
  - busy=1 for exactly 64 cycles, hit forced 0, updates ignored; afterwards all lookups miss.
  - enable=0 for 5 cycles mid-sweep extends busy to 69 cycles.
- Assert reset at sweep cycle 10 -> next cycle busy=0, all entries miss, mispredict_cnt=0. With STAT_W=4, 20 mispredicts -> mispredict_cnt holds at 15.
